pcw_palette_loader: RTL and testbench

//  Captures a 16-byte fake-colour palette file (OSD "Load Palette", ioctl index 3) from the

---
 rtl/pcw_palette_loader_if.sv | 29 ++
 rtl/pcw_palette_loader.sv | 134 +++++++++++++
 tb/tb_pcw_palette_loader.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/pcw_palette_loader_if.sv
`default_nettype none
// ============================================================================
// pcw_palette_loader_if : data_io download byte stream toward the palette loader
// Revision: 1.0
// ============================================================================
interface pcw_palette_loader_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_data;

  modport master (
    output ioctl_download,
    output ioctl_index,
    output ioctl_wr,
    output ioctl_addr,
    output ioctl_data
  );

  modport slave (
    input ioctl_download,
    input ioctl_index,
    input ioctl_wr,
    input ioctl_addr,
    input ioctl_data
  );
endinterface
`default_nettype wire

// File: rtl/pcw_palette_loader.sv
`default_nettype none
// ============================================================================
// pcw_palette_loader : stages a palette file from data_io and commits it in vblank
// Revision: 1.0
// ============================================================================
module pcw_palette_loader #(
  parameter logic [7:0]             PAL_INDEX   = 8'd3,
  parameter int                     PAL_BYTES   = 16,
  parameter logic [8*PAL_BYTES-1:0] PAL_DEFAULT = 128'h00000032cd320000ff00ffff00000000
) (
  input  wire logic                     clk_sys,
  input  wire logic                     reset_n,
  pcw_palette_loader_if.slave           bus,
  input  wire logic                     vblank,
  output logic [8*PAL_BYTES-1:0]        palette,
  output logic                          pal_loaded,
  output logic                          pal_error,
  output logic                          busy
);

  localparam int c_AW = (PAL_BYTES > 1) ? $clog2(PAL_BYTES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [7:0]              r_stage [PAL_BYTES];
  logic [PAL_BYTES-1:0]    r_mask;
  logic [8*PAL_BYTES-1:0]  w_stage_flat;
  logic                    w_start;
  logic                    w_addr_ok;
  logic                    w_byte_wr;
  logic                    w_complete;
  logic [c_AW-1:0]         w_slot;
  logic                    w_clear_mask;
  logic                    w_set_error;
  logic                    w_commit;

  assign w_start    = bus.ioctl_download && (bus.ioctl_index == PAL_INDEX);
  assign w_addr_ok  = bus.ioctl_addr < 16'(PAL_BYTES);
  assign w_slot     = bus.ioctl_addr[c_AW-1:0];
  assign w_complete = &r_mask;
  // Out-of-range bytes are dropped silently and never count toward completeness.
  assign w_byte_wr  = (r_state == ST_LOAD) && bus.ioctl_download && bus.ioctl_wr && w_addr_ok;

  genvar k;
  generate
    for (k = 0; k < PAL_BYTES; k++) begin : g_pack
      assign w_stage_flat[8*PAL_BYTES-1-8*k -: 8] = r_stage[k];
    end
  endgenerate

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear_mask = 1'b0;
    w_set_error  = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_next = ST_LOAD;
          w_clear_mask = 1'b1;
        end
      end
      ST_LOAD: begin
        if (!bus.ioctl_download) begin
          if (w_complete) begin
            w_state_next = ST_PEND;
          end else begin
            w_state_next = ST_IDLE;
            w_set_error  = 1'b1;
          end
        end
      end
      ST_PEND: begin
        // A fresh palette download supersedes the one still waiting for vblank.
        if (w_start) begin
          w_state_next = ST_LOAD;
          w_clear_mask = 1'b1;
        end else if (vblank) begin
          w_state_next = ST_IDLE;
          w_commit     = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PAL_BYTES; i++) begin
        r_stage[i] <= 8'h00;
      end
      r_mask     <= '0;
      palette    <= PAL_DEFAULT;
      pal_loaded <= 1'b0;
      pal_error  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (w_state_next != ST_IDLE);
      if (w_clear_mask) begin
        r_mask    <= '0;
        pal_error <= 1'b0;
      end
      if (w_set_error) begin
        pal_error <= 1'b1;
      end
      if (w_byte_wr) begin
        r_stage[w_slot] <= bus.ioctl_data;
        r_mask[w_slot]  <= 1'b1;
      end
      if (w_commit) begin
        palette    <= w_stage_flat;
        pal_loaded <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pcw_palette_loader.sv
`default_nettype none
// ============================================================================
// tb_pcw_palette_loader : directed self-checking bench for pcw_palette_loader
// Revision: 1.0
// ============================================================================
module tb_pcw_palette_loader;

  localparam logic [127:0] c_DEFAULT = 128'h00000032cd320000ff00ffff00000000;
  localparam logic [127:0] c_PAL_A   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_PAL_B   = 128'h303132333422363738393a3b3c3d3e3f;
  localparam logic [127:0] c_PAL_C   = 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf;

  logic         clk_sys = 1'b0;
  logic         reset_n = 1'b0;
  logic         vblank  = 1'b0;
  logic [127:0] palette;
  logic         pal_loaded;
  logic         pal_error;
  logic         busy;
  int           n_checks = 0;
  int           n_fail   = 0;

  pcw_palette_loader_if bus ();

  pcw_palette_loader dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .bus        (bus),
    .vblank     (vblank),
    .palette    (palette),
    .pal_loaded (pal_loaded),
    .pal_error  (pal_error),
    .busy       (busy)
  );

  always #8 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic start_dl(input logic [7:0] idx);
    bus.ioctl_download = 1'b1;
    bus.ioctl_index    = idx;
    tick();
  endtask

  task automatic wr_byte(input logic [15:0] addr, input logic [7:0] data);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = addr;
    bus.ioctl_data = data;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic stop_dl();
    bus.ioctl_download = 1'b0;
    tick();
  endtask

  initial begin
    bus.ioctl_download = 1'b0;
    bus.ioctl_index    = 8'd0;
    bus.ioctl_wr       = 1'b0;
    bus.ioctl_addr     = 16'd0;
    bus.ioctl_data     = 8'd0;
    #20;
    chk("rst_palette", palette, c_DEFAULT);
    chk("rst_loaded", 128'(pal_loaded), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_error", 128'(pal_error), 128'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Full file, commit held until vblank
    start_dl(8'd3);
    chk("t2_busy_load", 128'(busy), 128'd1);
    for (int i = 0; i < 16; i++) wr_byte(16'(i), 8'(i));
    stop_dl();
    chk("t2_busy_pend", 128'(busy), 128'd1);
    chk("t2_pal_pend", palette, c_DEFAULT);
    for (int i = 0; i < 50; i++) tick();
    chk("t2_pal_noblank", palette, c_DEFAULT);
    chk("t2_loaded_pre", 128'(pal_loaded), 128'd0);
    vblank = 1'b1;
    tick();
    vblank = 1'b0;
    chk("t2_pal_commit", palette, c_PAL_A);
    chk("t2_loaded", 128'(pal_loaded), 128'd1);
    chk("t2_busy_idle", 128'(busy), 128'd0);

    // Short file is discarded
    start_dl(8'd3);
    for (int i = 0; i < 15; i++) wr_byte(16'(i), 8'(8'ha0 + i));
    stop_dl();
    chk("t3_error", 128'(pal_error), 128'd1);
    chk("t3_busy", 128'(busy), 128'd0);
    vblank = 1'b1;
    tick();
    tick();
    vblank = 1'b0;
    chk("t3_pal_kept", palette, c_PAL_A);

    // Overlong file with duplicate address; vblank already high when pending
    start_dl(8'd3);
    chk("t5_error_clr", 128'(pal_error), 128'd0);
    wr_byte(16'd5, 8'h11);
    for (int i = 0; i < 16; i++) if (i != 5) wr_byte(16'(i), 8'(8'h30 + i));
    wr_byte(16'd5, 8'h22);
    wr_byte(16'd16, 8'hee);
    wr_byte(16'd17, 8'hee);
    vblank = 1'b1;
    stop_dl();
    chk("t5_pal_pend", palette, c_PAL_A);
    chk("t5_busy_pend", 128'(busy), 128'd1);
    tick();
    vblank = 1'b0;
    chk("t5_pal_commit", palette, c_PAL_B);
    chk("t5_busy_idle", 128'(busy), 128'd0);

    // Non-palette index never leaves idle
    vblank = 1'b1;
    start_dl(8'd1);
    chk("t4_busy_start", 128'(busy), 128'd0);
    for (int i = 0; i < 16; i++) wr_byte(16'(i), 8'hff);
    stop_dl();
    tick();
    vblank = 1'b0;
    chk("t4_busy", 128'(busy), 128'd0);
    chk("t4_pal", palette, c_PAL_B);
    chk("t4_error", 128'(pal_error), 128'd0);

    // Pending file abandoned by a new download, then async reset mid-load
    start_dl(8'd3);
    for (int i = 0; i < 16; i++) wr_byte(16'(i), 8'(8'h50 + i));
    stop_dl();
    chk("t6_busy_pend", 128'(busy), 128'd1);
    start_dl(8'd3);
    for (int i = 0; i < 8; i++) wr_byte(16'(i), 8'h77);
    vblank = 1'b1;
    tick();
    tick();
    chk("t6_pal_abandon", palette, c_PAL_B);
    chk("t6_busy_load", 128'(busy), 128'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_rst_pal", palette, c_DEFAULT);
    chk("t6_rst_busy", 128'(busy), 128'd0);
    chk("t6_rst_loaded", 128'(pal_loaded), 128'd0);
    bus.ioctl_download = 1'b0;
    vblank = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Index change after start is ignored; fresh file commits normally
    start_dl(8'd3);
    bus.ioctl_index = 8'd0;
    for (int i = 0; i < 16; i++) wr_byte(16'(i), 8'(8'hc0 + i));
    vblank = 1'b1;
    stop_dl();
    chk("t7_pal_pend", palette, c_DEFAULT);
    tick();
    vblank = 1'b0;
    chk("t7_pal_commit", palette, c_PAL_C);
    chk("t7_loaded", 128'(pal_loaded), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
